// File: rtl/c6288_check_seq_if.sv
// rtl/c6288_check_seq_if.sv - operand handshake and result bundle for the c6288 check stage
//
// Signals:
//   in_valid / in_ready   operand-pair handshake (master drives valid, slave drives ready)
//   in_a, in_b            16-bit multiplicand / multiplier
//   res_valid             one-cycle result strobe from the slave
//   res_pass              sampled product matched the golden product
//   res_got, res_exp      sampled multiplier output and golden product
interface c6288_check_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        res_valid;
    logic        res_pass;
    logic [31:0] res_got;
    logic [31:0] res_exp;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, res_valid, res_pass, res_got, res_exp
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, res_valid, res_pass, res_got, res_exp
    );
endinterface

// File: rtl/c6288_check_seq.sv
// rtl/c6288_check_seq.sv - in-system check stage around the c6288 16x16 array multiplier
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   bus (slave)     operand handshake in, per-pattern result out
//   dut_a, dut_b    registered operand drive to the multiplier (A: gat1..gat256, B: gat273..gat528)
//   dut_p           multiplier product, bit0 = gat_out545 .. bit31 = gat_out6288
//   pass_cnt        saturating count of passing patterns
//   fail_cnt        saturating count of failing patterns
//   cnt_clr         synchronous clear of both counters (wins over a same-edge update)
//   all_pass        at least one pass and no fails
module c6288_check_seq #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    c6288_check_seq_if.slave      bus,
    output logic [15:0]           dut_a,
    output logic [15:0]           dut_b,
    input  logic [31:0]           dut_p,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    input  logic                  cnt_clr,
    output logic                  all_pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic        sample;

    logic [31:0] mcand;
    logic [15:0] mplr;
    logic [31:0] acc;
    logic [3:0]  iter;
    logic [31:0] add_term;
    logic [31:0] golden;
    logic        pass_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        accept        = 1'b0;
        sample        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // Sixteenth shift-add step: the product completes on this edge.
                if (iter == 4'd15) begin
                    sample   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The accumulator after this step; on the last step it is the full product,
    // so the same value feeds both the engine and the compare.
    assign add_term = mplr[0] ? mcand : 32'd0;
    assign golden   = acc + add_term;
    assign pass_now = (dut_p == golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_a        <= 16'd0;
            dut_b        <= 16'd0;
            mcand        <= 32'd0;
            mplr         <= 16'd0;
            acc          <= 32'd0;
            iter         <= 4'd0;
            bus.res_got  <= 32'd0;
            bus.res_exp  <= 32'd0;
            bus.res_pass <= 1'b0;
        end else if (accept) begin
            dut_a <= bus.in_a;
            dut_b <= bus.in_b;
            mcand <= {16'd0, bus.in_a};
            mplr  <= bus.in_b;
            acc   <= 32'd0;
            iter  <= 4'd0;
        end else if (state == RUN) begin
            acc   <= golden;
            mcand <= {mcand[30:0], 1'b0};
            mplr  <= {1'b0, mplr[15:1]};
            iter  <= iter + 4'd1;
            if (sample) begin
                bus.res_exp  <= golden;
                bus.res_got  <= dut_p;
                bus.res_pass <= pass_now;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (cnt_clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (sample) begin
            if (pass_now) begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end else begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                end
            end
        end
    end

    assign all_pass = (fail_cnt == '0) && (pass_cnt != '0);

endmodule
